nukv_value_set: RTL and testbench

- Write-side counterpart of the value-get stage. Takes SET requests (key + header + meta) plus a 64-bit value stream from the request parser.
- Issues one memory write command per SET and packs the value into 512-bit memory write words.
- Forwards the request record downstream once its write data has been fully handed to memory.
- Non-SET requests pass through unchanged and consume no value beats.

---
 rtl/nukv_value_set.sv | 255 +++++++++++++++++++++++++
 tb/tb_nukv_value_set.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nukv_value_set.sv
// SET write stage: issues one memory write command per SET request, packs the 64-bit value
// stream into 512-bit memory words, and forwards the request record once its data is written.
module nukv_value_set #(
  parameter int KEY_WIDTH    = 128,
  parameter int HEADER_WIDTH = 42,
  parameter int META_WIDTH   = 96,
  parameter int MEMORY_WIDTH = 512,
  localparam int W = KEY_WIDTH + HEADER_WIDTH + META_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            input_data,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [63:0]             value_data,
  input  logic                    value_valid,
  input  logic                    value_last,
  output logic                    value_ready,
  output logic [30:0]             wrcmd_addr,
  output logic [7:0]              wrcmd_len,
  output logic                    wrcmd_valid,
  input  logic                    wrcmd_ready,
  output logic [MEMORY_WIDTH-1:0] wrdata_data,
  output logic                    wrdata_valid,
  output logic                    wrdata_last,
  input  logic                    wrdata_ready,
  output logic [W-1:0]            output_data,
  output logic                    output_valid,
  output logic                    output_err,
  input  logic                    output_ready,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a
  // valid never drops and its data never changes until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, PACK = 2'd2, DRAIN = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [W-1:0]            rec_q, rec_d, out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [30:0]             cmd_addr_q, cmd_addr_d;
  logic [7:0]              cmd_len_q, cmd_len_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [MEMORY_WIDTH-1:0] wr_data_q, wr_data_d, buf_q, buf_d, lane_buf;
  logic                    wr_valid_q, wr_valid_d, wr_last_q, wr_last_d;
  logic [2:0]              idx_q, idx_d;
  logic [9:0]              remaining_q, remaining_d;
  logic [7:0]              words_left_q, words_left_d;
  logic                    err_q, err_d, long_q, long_d;
  logic                    value_done_q, value_done_d, fin_q, fin_d;
  logic                    beat_final, done_now, fwd, fwd_err;
  logic [10:0]             len_sum;

  logic [1:0]  in_op;
  logic [9:0]  in_len;
  logic [30:0] in_addr;
  logic        slot_free, word_free, wr_fire;

  assign in_op     = input_data[W-8 +: 2];
  assign in_len    = input_data[KEY_WIDTH+31 +: 10];
  assign in_addr   = input_data[KEY_WIDTH +: 31];
  assign slot_free = !out_valid_q || output_ready;
  assign word_free = !wr_valid_q || wrdata_ready;
  assign wr_fire   = wr_valid_q && wrdata_ready;

  always_comb begin
    state_d      = state_q;
    rec_d        = rec_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !output_ready;
    out_err_d    = out_err_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    cmd_valid_d  = cmd_valid_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = wr_valid_q && !wrdata_ready;
    wr_last_d    = wr_last_q && !wrdata_ready;
    buf_d        = buf_q;
    idx_d        = idx_q;
    remaining_d  = remaining_q;
    words_left_d = words_left_q;
    err_d        = err_q;
    long_d       = long_q;
    value_done_d = value_done_q;
    fin_d        = fin_q;
    input_ready  = 1'b0;
    value_ready  = 1'b0;
    lane_buf     = buf_q;
    beat_final   = 1'b0;
    done_now     = 1'b0;
    fwd          = 1'b0;
    fwd_err      = 1'b0;
    len_sum      = {1'b0, in_len} + 11'd7;

    case (state_q)
      IDLE: begin
        if (input_valid && slot_free && !rst) begin
          input_ready = 1'b1;
          rec_d       = input_data;
          if (in_op == 2'b01 && in_len != 10'd0) begin
            cmd_addr_d   = in_addr;
            cmd_len_d    = len_sum[10:3];
            cmd_valid_d  = 1'b1;
            remaining_d  = in_len;
            words_left_d = len_sum[10:3];
            idx_d        = 3'd0;
            buf_d        = '0;
            err_d        = 1'b0;
            long_d       = 1'b0;
            value_done_d = 1'b0;
            fin_d        = 1'b0;
            state_d      = CMD;
          end else begin
            out_data_d  = input_data;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
          end
        end
      end
      CMD: begin
        if (wrcmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = PACK;
        end
      end
      PACK: begin
        if (!fin_q && word_free && !rst) begin
          if (!value_done_q) begin
            value_ready = 1'b1;
            if (value_valid) begin
              beat_final = (remaining_q == 10'd1) || value_last;
              lane_buf[{idx_q, 6'b0} +: 64] = value_data;
              buf_d       = lane_buf;
              idx_d       = idx_q + 3'd1;
              remaining_d = remaining_q - 10'd1;
              if (idx_q == 3'd7 || beat_final) begin
                wr_data_d    = lane_buf;
                wr_valid_d   = 1'b1;
                wr_last_d    = (words_left_q == 8'd1);
                words_left_d = words_left_q - 8'd1;
                buf_d        = '0;
                idx_d        = 3'd0;
              end
              if (beat_final) begin
                value_done_d = 1'b1;
                if (!value_last) begin
                  long_d = 1'b1;
                  err_d  = 1'b1;
                end else if (remaining_q != 10'd1) begin
                  err_d = 1'b1;
                end
              end
            end
          end else if (words_left_q != 8'd0) begin
            // Value ended early: fill the rest of the command with zero words.
            wr_data_d    = '0;
            wr_valid_d   = 1'b1;
            wr_last_d    = (words_left_q == 8'd1);
            words_left_d = words_left_q - 8'd1;
          end
        end
        done_now = fin_q || (wr_fire && wr_last_q);
        if (done_now) begin
          if (long_q) begin
            state_d = DRAIN;
            fin_d   = 1'b0;
          end else if (slot_free) begin
            fwd     = 1'b1;
            fwd_err = err_q;
            state_d = IDLE;
            fin_d   = 1'b0;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!fin_q && !rst) begin
          value_ready = 1'b1;
          done_now    = value_valid && value_last;
        end
        if (fin_q || done_now) begin
          if (slot_free) begin
            fwd     = 1'b1;
            fwd_err = 1'b1;
            state_d = IDLE;
            fin_d   = 1'b0;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fwd) begin
      out_data_d  = rec_q;
      out_valid_d = 1'b1;
      out_err_d   = fwd_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_last_q    <= 1'b0;
      idx_q        <= 3'd0;
      remaining_q  <= 10'd0;
      words_left_q <= 8'd0;
      err_q        <= 1'b0;
      long_q       <= 1'b0;
      value_done_q <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      cmd_valid_q  <= cmd_valid_d;
      wr_valid_q   <= wr_valid_d;
      wr_last_q    <= wr_last_d;
      idx_q        <= idx_d;
      remaining_q  <= remaining_d;
      words_left_q <= words_left_d;
      err_q        <= err_d;
      long_q       <= long_d;
      value_done_q <= value_done_d;
      fin_q        <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    rec_q      <= rec_d;
    out_data_q <= out_data_d;
    cmd_addr_q <= cmd_addr_d;
    cmd_len_q  <= cmd_len_d;
    wr_data_q  <= wr_data_d;
    buf_q      <= buf_d;
  end

  assign wrcmd_addr   = cmd_addr_q;
  assign wrcmd_len    = cmd_len_q;
  assign wrcmd_valid  = cmd_valid_q;
  assign wrdata_data  = wr_data_q;
  assign wrdata_valid = wr_valid_q;
  assign wrdata_last  = wr_last_q;
  assign output_data  = out_data_q;
  assign output_valid = out_valid_q;
  assign output_err   = out_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_nukv_value_set.sv
// Directed bench for nukv_value_set: pass-through, exact/partial/short/long SETs, stalls and
// mid-operation reset, with captured traffic compared against hand-built expected queues.
module tb_nukv_value_set;
  localparam int W = 266;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   input_data;
  logic           input_valid, input_ready;
  logic [63:0]    value_data;
  logic           value_valid, value_last, value_ready;
  logic [30:0]    wrcmd_addr;
  logic [7:0]     wrcmd_len;
  logic           wrcmd_valid, wrcmd_ready;
  logic [511:0]   wrdata_data;
  logic           wrdata_valid, wrdata_last, wrdata_ready;
  logic [W-1:0]   output_data;
  logic           output_valid, output_err, output_ready;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  nukv_value_set dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
    .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
    .value_ready(value_ready),
    .wrcmd_addr(wrcmd_addr), .wrcmd_len(wrcmd_len), .wrcmd_valid(wrcmd_valid),
    .wrcmd_ready(wrcmd_ready),
    .wrdata_data(wrdata_data), .wrdata_valid(wrdata_valid), .wrdata_last(wrdata_last),
    .wrdata_ready(wrdata_ready),
    .output_data(output_data), .output_valid(output_valid), .output_err(output_err),
    .output_ready(output_ready), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int beats_taken = 0;

  logic [511:0] got_w[$], exp_w[$];
  logic         got_wl[$], exp_wl[$];
  logic [38:0]  got_c[$], exp_c[$];
  logic [W-1:0] got_o[$], exp_o[$];
  logic         got_oe[$], exp_oe[$];

  // Monitor: record every completed transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wrdata_valid && wrdata_ready) begin
        got_w.push_back(wrdata_data);
        got_wl.push_back(wrdata_last);
      end
      if (wrcmd_valid && wrcmd_ready) got_c.push_back({wrcmd_len, wrcmd_addr});
      if (output_valid && output_ready) begin
        got_o.push_back(output_data);
        got_oe.push_back(output_err);
      end
      if (value_valid && value_ready) beats_taken++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_rec(input logic [1:0] op, input logic [30:0] addr,
                                          input logic [9:0] len, input logic [31:0] tag);
    logic [W-1:0] r;
    r = '0;
    r[31:0]     = tag;
    r[100 +: 8] = tag[7:0];
    r[128 +: 31] = addr;
    r[159 +: 10] = len;
    r[180 +: 16] = 16'hBEEF;
    r[258 +: 2]  = op;
    return r;
  endfunction

  task automatic send_req(input logic [W-1:0] rec);
    int g;
    input_data  = rec;
    input_valid = 1'b1;
    #1;
    g = 0;
    while (!input_ready && g < 50) begin
      tick();
      g++;
    end
    chk_b("input_ready", 32'(input_ready), 32'd1);
    tick();
    input_valid = 1'b0;
  endtask

  task automatic do_cmd();
    wrcmd_ready = 1'b1;
    tick();
    wrcmd_ready = 1'b0;
  endtask

  task automatic feed(input int n, input logic [63:0] base, input int last_idx);
    int g;
    for (int i = 0; i < n; i++) begin
      value_valid = 1'b1;
      value_data  = base + 64'(i);
      value_last  = (i == last_idx);
      #1;
      g = 0;
      while (!value_ready && g < 50) begin
        tick();
        g++;
      end
      chk_b("value_ready", 32'(value_ready), 32'd1);
      tick();
    end
    value_valid = 1'b0;
    value_last  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int g;
    g = 0;
    while (got_o.size() < n && g < 200) begin
      tick();
      g++;
    end
    chk_b("out_count", 32'(got_o.size()), 32'(n));
  endtask

  task automatic check_all();
    logic [511:0] a, b;
    chk_b("cmd_count", 32'(got_c.size()), 32'(exp_c.size()));
    while (got_c.size() > 0 && exp_c.size() > 0) begin
      a = 512'(got_c.pop_front());
      b = 512'(exp_c.pop_front());
      chk_w("wrcmd", a, b);
    end
    chk_b("word_count", 32'(got_w.size()), 32'(exp_w.size()));
    while (got_w.size() > 0 && exp_w.size() > 0) begin
      a = got_w.pop_front();
      b = exp_w.pop_front();
      chk_w("wr_word", a, b);
      a = 512'(got_wl.pop_front());
      b = 512'(exp_wl.pop_front());
      chk_w("wr_last", a, b);
    end
    chk_b("rec_count", 32'(got_o.size()), 32'(exp_o.size()));
    while (got_o.size() > 0 && exp_o.size() > 0) begin
      a = 512'(got_o.pop_front());
      b = 512'(exp_o.pop_front());
      chk_w("out_rec", a, b);
      a = 512'(got_oe.pop_front());
      b = 512'(exp_oe.pop_front());
      chk_w("out_err", a, b);
    end
    got_c.delete(); exp_c.delete(); got_w.delete(); exp_w.delete();
    got_wl.delete(); exp_wl.delete(); got_o.delete(); exp_o.delete();
    got_oe.delete(); exp_oe.delete();
  endtask

  logic [W-1:0]   rec_a, rec_b, rec_c;
  logic [511:0]   w0, w1;
  int             beats0;

  initial begin
    rst = 1'b1; input_valid = 1'b0; input_data = '0;
    value_valid = 1'b0; value_data = '0; value_last = 1'b0;
    wrcmd_ready = 1'b0; wrdata_ready = 1'b1; output_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk_b("rst_output_valid", 32'(output_valid), 32'd0);
    chk_b("rst_output_err", 32'(output_err), 32'd0);
    chk_b("rst_wrcmd_valid", 32'(wrcmd_valid), 32'd0);
    chk_b("rst_wrdata_valid", 32'(wrdata_valid), 32'd0);
    chk_b("rst_wrdata_last", 32'(wrdata_last), 32'd0);
    chk_b("rst_input_ready", 32'(input_ready), 32'd0);
    chk_b("rst_value_ready", 32'(value_ready), 32'd0);
    chk_b("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Pass-through: GET then DELETE back to back, then SET with len=0
    rec_a = mk_rec(2'b00, 31'h55, 10'd4, 32'h1111);
    rec_b = mk_rec(2'b10, 31'h66, 10'd0, 32'h2222);
    rec_c = mk_rec(2'b01, 31'h77, 10'd0, 32'h2323);
    input_data = rec_a; input_valid = 1'b1;
    #1;
    chk_b("pt_in_ready0", 32'(input_ready), 32'd1);
    tick();
    chk_b("pt_out_valid0", 32'(output_valid), 32'd1);
    chk_w("pt_out_data0", 512'(output_data), 512'(rec_a));
    input_data = rec_b;
    #1;
    chk_b("pt_in_ready1", 32'(input_ready), 32'd1);
    tick();
    input_valid = 1'b0;
    chk_b("pt_out_valid1", 32'(output_valid), 32'd1);
    chk_w("pt_out_data1", 512'(output_data), 512'(rec_b));
    chk_b("pt_out_err1", 32'(output_err), 32'd0);
    chk_b("pt_wrcmd_valid", 32'(wrcmd_valid), 32'd0);
    chk_b("pt_value_ready", 32'(value_ready), 32'd0);
    send_req(rec_c);
    chk_b("pt_len0_state", 32'(dbg_state), 32'd0);
    chk_b("pt_len0_wrcmd", 32'(wrcmd_valid), 32'd0);
    tick();
    chk_b("pt_out_idle", 32'(output_valid), 32'd0);
    exp_o.push_back(rec_a); exp_oe.push_back(1'b0);
    exp_o.push_back(rec_b); exp_oe.push_back(1'b0);
    exp_o.push_back(rec_c); exp_oe.push_back(1'b0);
    check_all();

    // Output backpressure: record held, no new input taken
    rec_a = mk_rec(2'b11, 31'h1, 10'd1, 32'h4444);
    rec_b = mk_rec(2'b00, 31'h2, 10'd2, 32'h5555);
    output_ready = 1'b0;
    input_data = rec_a; input_valid = 1'b1;
    tick();
    chk_w("bp_out_data", 512'(output_data), 512'(rec_a));
    input_data = rec_b;
    #1;
    chk_b("bp_in_ready_blocked", 32'(input_ready), 32'd0);
    tick();
    chk_b("bp_out_held", 32'(output_valid), 32'd1);
    chk_w("bp_out_data_held", 512'(output_data), 512'(rec_a));
    output_ready = 1'b1;
    #1;
    chk_b("bp_in_ready_free", 32'(input_ready), 32'd1);
    tick();
    input_valid = 1'b0;
    chk_w("bp_out_data2", 512'(output_data), 512'(rec_b));
    tick();
    exp_o.push_back(rec_a); exp_oe.push_back(1'b0);
    exp_o.push_back(rec_b); exp_oe.push_back(1'b0);
    check_all();

    // Exact-multiple SET: len=16 -> two words
    rec_a = mk_rec(2'b01, 31'h100, 10'd16, 32'h3333);
    send_req(rec_a);
    chk_b("ex_wrcmd_valid", 32'(wrcmd_valid), 32'd1);
    chk_b("ex_wrcmd_addr", 32'(wrcmd_addr), 32'h100);
    chk_b("ex_wrcmd_len", 32'(wrcmd_len), 32'd2);
    chk_b("ex_state_cmd", 32'(dbg_state), 32'd1);
    value_valid = 1'b1; value_data = 64'hDEAD;
    #1;
    chk_b("ex_value_ready_cmd", 32'(value_ready), 32'd0);
    value_valid = 1'b0;
    do_cmd();
    chk_b("ex_wrcmd_dropped", 32'(wrcmd_valid), 32'd0);
    chk_b("ex_state_pack", 32'(dbg_state), 32'd2);
    feed(8, 64'd0, -1);
    w0 = '0;
    for (int i = 0; i < 8; i++) w0[i*64 +: 64] = 64'(i);
    w1 = '0;
    for (int i = 0; i < 8; i++) w1[i*64 +: 64] = 64'(i + 8);
    chk_b("ex_word0_valid", 32'(wrdata_valid), 32'd1);
    chk_w("ex_word0_data", wrdata_data, w0);
    chk_b("ex_word0_last", 32'(wrdata_last), 32'd0);
    feed(8, 64'd8, 7);
    wait_out(1);
    exp_c.push_back({8'd2, 31'h100});
    exp_w.push_back(w0); exp_wl.push_back(1'b0);
    exp_w.push_back(w1); exp_wl.push_back(1'b1);
    exp_o.push_back(rec_a); exp_oe.push_back(1'b0);
    check_all();

    // Partial SET: len=3 -> one padded word
    rec_a = mk_rec(2'b01, 31'h2A0, 10'd3, 32'h6666);
    send_req(rec_a);
    chk_b("pa_wrcmd_len", 32'(wrcmd_len), 32'd1);
    do_cmd();
    feed(3, 64'hA5A5_0000_0000_0000, 2);
    chk_b("pa_word_valid", 32'(wrdata_valid), 32'd1);
    chk_b("pa_word_last", 32'(wrdata_last), 32'd1);
    tick();
    chk_b("pa_out_latency", 32'(output_valid), 32'd1);
    chk_b("pa_out_err", 32'(output_err), 32'd0);
    tick();
    w0 = '0;
    w0[63:0]    = 64'hA5A5_0000_0000_0000;
    w0[127:64]  = 64'hA5A5_0000_0000_0001;
    w0[191:128] = 64'hA5A5_0000_0000_0002;
    exp_c.push_back({8'd1, 31'h2A0});
    exp_w.push_back(w0); exp_wl.push_back(1'b1);
    exp_o.push_back(rec_a); exp_oe.push_back(1'b0);
    check_all();

    // Short value: len=10, value_last on the 4th beat
    rec_a = mk_rec(2'b01, 31'h300, 10'd10, 32'h7777);
    send_req(rec_a);
    chk_b("sh_wrcmd_len", 32'(wrcmd_len), 32'd2);
    do_cmd();
    feed(4, 64'h500, 3);
    wait_out(1);
    w0 = '0;
    for (int i = 0; i < 4; i++) w0[i*64 +: 64] = 64'h500 + 64'(i);
    exp_c.push_back({8'd2, 31'h300});
    exp_w.push_back(w0); exp_wl.push_back(1'b0);
    exp_w.push_back('0); exp_wl.push_back(1'b1);
    exp_o.push_back(rec_a); exp_oe.push_back(1'b1);
    check_all();

    // Long value with write-data backpressure: len=2, 5 beats
    rec_a = mk_rec(2'b01, 31'h400, 10'd2, 32'h8888);
    beats0 = beats_taken;
    wrdata_ready = 1'b0;
    send_req(rec_a);
    do_cmd();
    feed(2, 64'h600, -1);
    w0 = '0;
    w0[63:0]   = 64'h600;
    w0[127:64] = 64'h601;
    value_valid = 1'b1; value_data = 64'h602; value_last = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_b("lg_stall_valid", 32'(wrdata_valid), 32'd1);
      chk_w("lg_stall_data", wrdata_data, w0);
      chk_b("lg_stall_value_ready", 32'(value_ready), 32'd0);
      tick();
    end
    wrdata_ready = 1'b1;
    tick();
    chk_b("lg_state_drain", 32'(dbg_state), 32'd3);
    feed(3, 64'h602, 2);
    wait_out(1);
    chk_b("lg_beats_taken", 32'(beats_taken - beats0), 32'd5);
    exp_c.push_back({8'd1, 31'h400});
    exp_w.push_back(w0); exp_wl.push_back(1'b1);
    exp_o.push_back(rec_a); exp_oe.push_back(1'b1);
    check_all();

    // Reset in PACK after 3 of 8 beats, then a len=1 SET
    rec_a = mk_rec(2'b01, 31'h500, 10'd8, 32'h9999);
    send_req(rec_a);
    do_cmd();
    feed(3, 64'h700, -1);
    rst = 1'b1;
    value_valid = 1'b1; value_data = 64'h703;
    #1;
    chk_b("rs_value_ready", 32'(value_ready), 32'd0);
    tick();
    chk_b("rs_wrcmd_valid", 32'(wrcmd_valid), 32'd0);
    chk_b("rs_wrdata_valid", 32'(wrdata_valid), 32'd0);
    chk_b("rs_output_valid", 32'(output_valid), 32'd0);
    chk_b("rs_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    value_valid = 1'b0;
    tick();
    exp_c.push_back({8'd1, 31'h500});
    check_all();
    rec_b = mk_rec(2'b01, 31'h200, 10'd1, 32'hAAAA);
    send_req(rec_b);
    chk_b("rs2_wrcmd_len", 32'(wrcmd_len), 32'd1);
    do_cmd();
    feed(1, 64'h77, 0);
    wait_out(1);
    w0 = '0;
    w0[63:0] = 64'h77;
    exp_c.push_back({8'd1, 31'h200});
    exp_w.push_back(w0); exp_wl.push_back(1'b1);
    exp_o.push_back(rec_b); exp_oe.push_back(1'b0);
    check_all();

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
